// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams NUMTAPS coefficients into the FIR filter's
// coefficient port (write_address/write_value/load). When the optional
// COEFF_VERIFY_EN macro is defined, every tap is read back and compared
// against a shadow copy. The result is reported as pass, err_count and err_addr.
module fir_coeff_loader #(
  parameter int NUMTAPS = 32,
  parameter int DW      = 12,
  parameter int AW      = 8,
  parameter int CW      = $clog2(NUMTAPS + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  input  logic [DW-1:0] coeff_in,
  input  logic          coeff_valid,
  output logic          coeff_ready,
  output logic [AW-1:0] write_address,
  output logic [DW-1:0] write_value,
  output logic          load,
  output logic [AW-1:0] read_address,
  input  logic [DW-1:0] read_value,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUMTAPS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_wa;
  logic [DW-1:0] r_wv;
  logic          r_load;
  logic          r_done;
  logic          r_pass;
  logic          w_accept;
  logic          w_start;
  logic          w_last_acc;

  assign coeff_ready = (r_state == S_WRITE);
  assign busy        = (r_state != S_IDLE);
  assign w_accept    = coeff_valid && coeff_ready;
  assign w_start     = (r_state == S_IDLE) && start;
  assign w_last_acc  = w_accept && (r_idx == LAST);

  assign write_address = r_wa;
  assign write_value   = r_wv;
  assign load          = r_load;
  assign done          = r_done;
  assign pass          = r_pass;

`ifdef COEFF_VERIFY_EN
  localparam int IW = $clog2(NUMTAPS);

  logic [DW-1:0] r_shadow [NUMTAPS];
  logic [AW-1:0] r_ra;
  logic          r_iss;
  logic          r_p1_vld;
  logic [AW-1:0] r_p1_addr;
  logic          r_last_cmp;
  logic [CW-1:0] r_err_cnt;
  logic [AW-1:0] r_err_addr;

  assign read_address = r_ra;
  assign err_count    = r_err_cnt;
  assign err_addr     = r_err_addr;

  // Shadow copy of every accepted coefficient (plain RAM, no reset)
  always_ff @(posedge Clk) begin
    if (w_accept) r_shadow[r_idx[IW-1:0]] <= coeff_in;
  end

  // Readback sweep: issue register plus one tracking stage; compare when the tracked address matures
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ra       <= '0;
      r_iss      <= 1'b0;
      r_p1_vld   <= 1'b0;
      r_p1_addr  <= '0;
      r_last_cmp <= 1'b0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else begin
      if (w_start) begin
        r_ra       <= '0;
        r_iss      <= 1'b0;
        r_p1_vld   <= 1'b0;
        r_last_cmp <= 1'b0;
        r_err_cnt  <= '0;
        r_err_addr <= '0;
      end
      if ((r_state == S_WRITE) && w_last_acc) begin
        r_ra  <= '0;
        r_iss <= 1'b1;
      end
      if (r_state == S_VERIFY) begin
        r_p1_vld  <= r_iss;
        r_p1_addr <= r_ra;
        if (r_ra != LAST) r_ra <= r_ra + AW'(1);
        else              r_iss <= 1'b0;
        if (r_p1_vld) begin
          if (read_value != r_shadow[r_p1_addr[IW-1:0]]) begin
            r_err_cnt <= r_err_cnt + CW'(1);
            if (r_err_cnt == '0) r_err_addr <= r_p1_addr;
          end
          if (r_p1_addr == LAST) r_last_cmp <= 1'b1;
        end
      end
      if (r_state == S_DONE) r_last_cmp <= 1'b0;
    end
  end
`else
  logic w_unused_rd;

  assign w_unused_rd  = ^read_value;
  assign read_address = '0;
  assign err_count    = '0;
  assign err_addr     = '0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WRITE;
`ifdef COEFF_VERIFY_EN
      S_WRITE:  if (w_last_acc) w_next = S_VERIFY;
      S_VERIFY: if (r_last_cmp) w_next = S_DONE;
`else
      S_WRITE:  if (w_last_acc) w_next = S_DONE;
      S_VERIFY: w_next = S_IDLE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write path: registered address/value/strobe on each accept
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx  <= '0;
      r_wa   <= '0;
      r_wv   <= '0;
      r_load <= 1'b0;
    end else begin
      r_load <= w_accept;
      if (w_start) r_idx <= '0;
      if (w_accept) begin
        r_wa  <= r_idx;
        r_wv  <= coeff_in;
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  // Completion pulse and sticky pass flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_start) r_pass <= 1'b0;
      if (r_state == S_DONE) begin
`ifdef COEFF_VERIFY_EN
        r_pass <= (r_err_cnt == '0);
`else
        r_pass <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a loopback filter model.
// Readback checks apply when COEFF_VERIFY_EN is defined.
module tb_fir_coeff_loader;
  localparam int N  = 32;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int CW = $clog2(N + 1);
`ifdef COEFF_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LAT = VER ? N + 3 : 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] coeff_in = '0;
  logic          coeff_valid = 1'b0;
  logic          coeff_ready;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_value;
  logic          load;
  logic [AW-1:0] read_address;
  logic [DW-1:0] read_value = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] err_addr;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] coef [N];
  logic [DW-1:0] fmem [256];
  logic          fault = 1'b0;
  logic          mon_en = 1'b0;
  logic          exp_load = 1'b0;
  logic [AW-1:0] exp_waddr = '0;
  int            half [16] = '{-3, 0, 1, 4, 10, 19, 31, 46, 64, 83, 103, 123, 142, 158, 170, 177};

  fir_coeff_loader #(.NUMTAPS(N), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .coeff_in(coeff_in),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .write_address(write_address), .write_value(write_value), .load(load),
    .read_address(read_address), .read_value(read_value), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 Clk = ~Clk;

  // Filter model: captures writes one edge after load, registered readback with optional faults
  always @(posedge Clk) begin
    if (load) fmem[write_address] <= write_value;
    if (fault && read_address == 8'd5)       read_value <= fmem[read_address] ^ 12'h001;
    else if (fault && read_address == 8'd20) read_value <= '0;
    else                                     read_value <= fmem[read_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor: load must follow each accept by one edge, addresses contiguous, values in order
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("load", 32'(load), 32'(exp_load));
      if (load) begin
        chk("waddr", 32'(write_address), 32'(exp_waddr));
        chk("wval", 32'(write_value), 32'(coef[exp_waddr[4:0]]));
        exp_waddr = exp_waddr + 8'd1;
      end
      exp_load = coeff_valid && coeff_ready;
    end else begin
      exp_load = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(coeff_ready), 0);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_waddr"}, 32'(write_address), 0);
    chk({tag, "_wval"}, 32'(write_value), 0);
    chk({tag, "_raddr"}, 32'(read_address), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_errcnt"}, 32'(err_count), 0);
    chk({tag, "_erraddr"}, 32'(err_addr), 0);
  endtask

  // One programming sequence; ntap < N stops right after the accept edge of tap ntap-1
  task automatic run_seq(input bit bp, input bit poke, input bit inj, input int ntap,
                         input int exp_err, input int exp_eaddr);
    int i = 0;
    int cyc = 0;
    int lat = 0;
    int exp_ra;
    fault = inj;
    @(posedge Clk); #1;
    start = 1'b1;
    exp_waddr = '0;
    mon_en = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(coeff_ready), 1);
    chk("pass_cleared", 32'(pass), 0);
    chk("errcnt_cleared", 32'(err_count), 0);
    while (i < ntap) begin
      coeff_in = coef[i[4:0]];
      coeff_valid = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start = poke && (i == 7);
      @(negedge Clk);
      if (coeff_valid && coeff_ready) i++;
      cyc++;
      @(posedge Clk); #1;
      if (cyc > 400) begin
        chk("write_timeout", 32'(i), 32'(ntap));
        break;
      end
    end
    coeff_valid = 1'b0;
    start = 1'b0;
    if (ntap < N) return;
    while (!done && lat < 100) begin
      exp_ra = VER ? ((lat < N - 1) ? lat : N - 1) : 0;
      chk("raddr", 32'(read_address), 32'(exp_ra));
      @(posedge Clk); #1;
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(LAT));
    chk("pass", 32'(pass), 32'(exp_err == 0));
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("err_addr", 32'(err_addr), 32'(exp_eaddr));
    chk("busy_at_done", 32'(busy), 0);
    @(posedge Clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    @(posedge Clk); #1;
    chk("pass_held", 32'(pass), 32'(exp_err == 0));
    chk("exp_loads", 32'(exp_waddr), 32'(N));
    mon_en = 1'b0;
    fault = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      coef[k]         = DW'(half[k]);
      coef[N - 1 - k] = DW'(half[k]);
    end

    // Reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      start       = 1'($urandom);
      coeff_valid = 1'($urandom);
      coeff_in    = DW'($urandom);
      @(negedge Clk);
      check_zero("rst");
    end
    start = 1'b0;
    coeff_valid = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Nominal streaming
    run_seq(1'b0, 1'b0, 1'b0, N, 0, 0);
    // Backpressure with a stray start during WRITE
    run_seq(1'b1, 1'b1, 1'b0, N, 0, 0);
    // Readback fault injection: bit flip on tap 5, zero on tap 20
    if (VER) run_seq(1'b0, 1'b0, 1'b1, N, 2, 5);

    // Reset right after the accept of tap 10
    run_seq(1'b0, 1'b0, 1'b0, 11, 0, 0);
    mon_en = 1'b0;
    Reset_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    // Restart must write address 0 first and complete cleanly
    run_seq(1'b0, 1'b0, 1'b0, N, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
